// File: rtl/rvj1_pipe_ctrl_pkg.sv
// Shared types and widths for the rvj1 pipeline controller and its scoreboard.
`timescale 1ns/1ps
package rvj1_pipe_ctrl_pkg;
    localparam int XLEN  = 32;
    localparam int RALEN = 5;

    typedef enum logic [1:0] {eRESET, eBOOT, eRUN, eHALT} rvj1_ctrl_fsm_e;

    typedef struct packed {
        logic             v;
        logic [RALEN-1:0] rd;
    } rvj1_sb_entry_t;

    function automatic logic addr_aligned(input logic [XLEN-1:0] a);
        return a[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/rvj1_scoreboard.sv
// In-flight register-write tracker: one entry per stage between issue and writeback.
`timescale 1ns/1ps
module rvj1_scoreboard
    import rvj1_pipe_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_v,
    input  logic [RALEN-1:0] push_rd,
    input  logic [RALEN-1:0] src_a,
    input  logic             use_a,
    input  logic [RALEN-1:0] src_b,
    input  logic             use_b,
    output logic             haz_a,
    output logic             haz_b
);
    rvj1_sb_entry_t [PIPE_DEPTH-1:0] sb_q;
    logic [PIPE_DEPTH-1:0]           hit_a, hit_b;

    // Shifts every cycle; a non-issuing cycle inserts a bubble so producers age out on time.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sb_q <= '0;
        end else begin
            sb_q[0].v  <= push_v;
            sb_q[0].rd <= push_rd;
            for (int i = 1; i < PIPE_DEPTH; i++)
                sb_q[i] <= sb_q[i-1];
        end
    end

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_cmp
        assign hit_a[g] = sb_q[g].v && (sb_q[g].rd == src_a);
        assign hit_b[g] = sb_q[g].v && (sb_q[g].rd == src_b);
    end

    assign haz_a = use_a && (src_a != '0) && (|hit_a);
    assign haz_b = use_b && (src_b != '0) && (|hit_b);
endmodule

// File: rtl/rvj1_pipe_ctrl.sv
// rvj1 core controller: boot sequencing, PC, RAW-hazard issue gating and branch redirect.
`timescale 1ns/1ps
module rvj1_pipe_ctrl
    import rvj1_pipe_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h8000_0000,
    parameter int              BOOT_WAIT  = 2,
    parameter int              PIPE_DEPTH = 2,
    parameter int              CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             dec_valid_i,
    input  logic [RALEN-1:0] rf_addr_a_i,
    input  logic [RALEN-1:0] rf_addr_b_i,
    input  logic             rpa_or_pc_i,
    input  logic             rpb_or_imm_i,
    input  logic [RALEN-1:0] rd_addr_i,
    input  logic             rd_we_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_addr_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic [XLEN-1:0]  program_counter_o,
    output logic             jmp_addr_valid_o,
    output logic [XLEN-1:0]  jmp_addr_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] perf_stall_o
);
    rvj1_ctrl_fsm_e   state_q;
    logic [3:0]       boot_cnt_q;
    logic [XLEN-1:0]  pc_q;
    logic             mis_q;
    logic [CNT_W-1:0] perf_q;
    logic             run, boot_last, br_ok, br_bad, haz_a, haz_b;

    assign run       = (state_q == eRUN);
    assign boot_last = (state_q == eBOOT) && (boot_cnt_q == 4'(BOOT_WAIT - 1));
    assign br_ok     = run && branch_taken_i && addr_aligned(branch_addr_i);
    assign br_bad    = run && branch_taken_i && !addr_aligned(branch_addr_i);

    assign stall_o          = dec_valid_i && (haz_a || haz_b) && run;
    assign issue_o          = dec_valid_i && run && !stall_o && !branch_taken_i;
    assign flush_o          = run && branch_taken_i;
    assign jmp_addr_valid_o = boot_last || br_ok;
    assign jmp_addr_o       = br_ok ? branch_addr_i : BOOT_ADDR;

    assign program_counter_o = pc_q;
    assign misalign_o        = mis_q;
    assign perf_stall_o      = perf_q;

    rvj1_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_v  (issue_o && rd_we_i && (rd_addr_i != '0)),
        .push_rd (rd_addr_i),
        .src_a   (rf_addr_a_i),
        .use_a   (!rpa_or_pc_i),
        .src_b   (rf_addr_b_i),
        .use_b   (!rpb_or_imm_i),
        .haz_a   (haz_a),
        .haz_b   (haz_b)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= eRESET;
            boot_cnt_q <= '0;
            pc_q       <= BOOT_ADDR;
            mis_q      <= 1'b0;
            perf_q     <= '0;
        end else begin
            case (state_q)
                eRESET: begin
                    state_q    <= eBOOT;
                    boot_cnt_q <= '0;
                end
                eBOOT: begin
                    if (boot_last) state_q <= eRUN;
                    else           boot_cnt_q <= boot_cnt_q + 4'd1;
                end
                eRUN: begin
                    if (br_bad) begin
                        state_q <= eHALT;
                        mis_q   <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Branch wins over issue; issue is already masked when a branch is taken.
            if (br_ok)        pc_q <= branch_addr_i;
            else if (issue_o) pc_q <= pc_q + XLEN'(4);

            if (stall_o && !(&perf_q))
                perf_q <= perf_q + CNT_W'(1);
        end
    end
endmodule
